// File: rtl/pl_text_memory_responder.sv
// rtl/pl_text_memory_responder.sv - pipelined instruction-fetch responder with loadable word storage
module pl_text_memory_responder #(
   parameter int          ADDR_WIDTH      = 10,
   parameter int          LATENCY         = 2,
   parameter int          MAX_OUTSTANDING = 4,
   parameter logic [31:0] OOR_DATA        = 32'h00000013
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [31:0]           inst_address,
   input  logic                  inst_read_enable,
   output logic                  inst_wait_req,
   output logic                  inst_valid,
   output logic [31:0]           inst_data,
   input  logic                  stall_inject,
   input  logic                  load_enable,
   input  logic [ADDR_WIDTH-1:0] load_address,
   input  logic [31:0]           load_data,
   output logic                  oor_error
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   if (ADDR_WIDTH < 1 || ADDR_WIDTH > 29) begin : g_bad_addr_width
      $error("ADDR_WIDTH must be in 1..29");
   end
   if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
      $error("LATENCY must be in 1..8");
   end
   if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 8) begin : g_bad_max_outstanding
      $error("MAX_OUTSTANDING must be in 1..8");
   end

   logic [31:0]           storage [DEPTH];
   logic [3:0]            outstanding;
   logic                  accept;
   logic                  out_of_range;
   logic [ADDR_WIDTH-1:0] read_index;
   logic [31:0]           read_word;
   logic [LATENCY-1:0]    pipe_valid;
   logic [31:0]           pipe_data [LATENCY];
   logic                  unused_addr_bits;

   assign inst_wait_req    = stall_inject || (outstanding == 4'(MAX_OUTSTANDING));
   assign accept           = inst_read_enable && !inst_wait_req;
   assign read_index       = inst_address[ADDR_WIDTH+1:2];
   assign out_of_range     = (inst_address >> (ADDR_WIDTH + 2)) != 32'd0;
   assign read_word        = out_of_range ? OOR_DATA : storage[read_index];
   assign unused_addr_bits = ^inst_address[1:0];

   // Storage ignores reset so a load coinciding with reset still lands.
   always_ff @(posedge clock) begin
      if (load_enable) begin
         storage[load_address] <= load_data;
      end
   end

   // Data is zeroed alongside valid so the output stage needs no gating.
   always_ff @(posedge clock) begin
      if (reset) begin
         pipe_valid <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            pipe_data[i] <= 32'd0;
         end
      end else begin
         pipe_valid[0] <= accept;
         pipe_data[0]  <= accept ? read_word : 32'd0;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_data[i]  <= pipe_data[i-1];
         end
      end
   end

   // A slot freed by the current response only becomes usable next cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         outstanding <= 4'd0;
      end else if (accept && !inst_valid) begin
         outstanding <= outstanding + 4'd1;
      end else if (!accept && inst_valid) begin
         outstanding <= outstanding - 4'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         oor_error <= 1'b0;
      end else if (accept && out_of_range) begin
         oor_error <= 1'b1;
      end
   end

   assign inst_valid = pipe_valid[LATENCY-1];
   assign inst_data  = pipe_data[LATENCY-1];
endmodule
